// File: rtl/pmem_pkg.sv
// Shared types and helpers for the parametrised memory slave.
// Holds the FSM state type, wait-counter width and byte-lane merge.
package pmem_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_DONE
    } pmem_state_e;

    localparam int WAIT_CNT_W = 4;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/pmem_array.sv
// DEPTH x DATA_WIDTH storage, byte-enabled synchronous write,
// combinational read.
module pmem_array
    import pmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        old_word = mem[waddr];
        merged   = old_word;
        for (int b = 0; b < LANES; b++) begin
            merged[8*b +: 8] = byte_merge(old_word[8*b +: 8],
                                          wdata[8*b +: 8], strb[b]);
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= merged;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_memory.sv
// Parametrised memory slave: penable/pready handshake, wait states,
// out-of-range error and a clearing sweep after reset.
module param_memory
    import pmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk_i,
    input  logic                    prst_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic                    pwr_rd_i,
    input  logic                    penable_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic                    pinit_done_o
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    pmem_state_e             state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]        sweep;

    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_wr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [STRB_W-1:0]       req_strb;

    logic                    in_range;
    logic [IDX_W-1:0]        req_idx;
    logic                    arr_we;
    logic [IDX_W-1:0]        arr_waddr;
    logic [DATA_WIDTH-1:0]   arr_wdata;
    logic [STRB_W-1:0]       arr_strb;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign in_range = ({1'b0, req_addr} < DEPTH_EXT);
    assign req_idx  = req_addr[IDX_W-1:0];

    // A reset edge must never commit a write, even mid-RESP.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = req_idx;
        arr_wdata = req_wdata;
        arr_strb  = req_strb;
        if (!prst_i) begin
            if (state == ST_INIT) begin
                arr_we    = 1'b1;
                arr_waddr = sweep;
                arr_wdata = '0;
                arr_strb  = '1;
            end else if (state == ST_RESP && req_wr && in_range) begin
                arr_we = 1'b1;
            end
        end
    end

    pmem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk  (pclk_i),
        .we   (arr_we),
        .waddr(arr_waddr),
        .wdata(arr_wdata),
        .strb (arr_strb),
        .raddr(req_idx),
        .rdata(rd_data)
    );

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state        <= ST_INIT;
            wait_cnt     <= '0;
            sweep        <= '0;
            req_addr     <= '0;
            req_wr       <= 1'b0;
            req_wdata    <= '0;
            req_strb     <= '0;
            prdata_o     <= '0;
            pready_o     <= 1'b0;
            pslverr_o    <= 1'b0;
            pinit_done_o <= 1'b0;
        end else begin
            prdata_o  <= '0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            unique case (state)
                ST_INIT: begin
                    if (sweep == SWEEP_LAST) begin
                        state        <= ST_IDLE;
                        pinit_done_o <= 1'b1;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (penable_i) begin
                        req_addr  <= paddr_i;
                        req_wr    <= pwr_rd_i;
                        req_wdata <= pwdata_i;
                        req_strb  <= pstrb_i;
                        if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    pready_o <= 1'b1;
                    if (!in_range) begin
                        pslverr_o <= 1'b1;
                    end else if (!req_wr) begin
                        prdata_o <= rd_data;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!penable_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
